// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush controller: per-source forwarding selects, load-use stall, and a
// single down-counting flush FSM whose length and reported cause depend on the triggering event.
module pipeline_hazard_ctrl #(
    parameter int REG_W          = 5,
    parameter int NSRC           = 2,
    parameter int ZERO_HARDWIRED = 0,
    parameter int FLUSH_RST      = 2,
    parameter int FLUSH_INT      = 2,
    parameter int FLUSH_BR       = 2,
    parameter int FLUSH_CALL     = 2,
    parameter int FLUSH_RET      = 3,
    parameter int CNT_W          = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSRC*REG_W-1:0]   src_addr,
    input  logic [NSRC-1:0]         src_read,
    input  logic [REG_W-1:0]        ex_addr,
    input  logic                    ex_wen,
    input  logic                    ex_is_load,
    input  logic [REG_W-1:0]        wb_addr,
    input  logic                    wb_wen,
    input  logic [3:0]              instr_type,
    input  logic                    branch_taken,
    input  logic                    interrupt,
    output logic [2*NSRC-1:0]       fwd_sel,
    output logic                    fetch_stall,
    output logic                    dec_nop,
    output logic                    pc_inc,
    output logic                    pc_load,
    output logic                    pc_reset,
    output logic                    flush_active,
    output logic [2:0]              flush_cause
);

    typedef enum logic {CHECK = 1'b0, FLUSH = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         cause_nxt;
    logic               load_use, call_det, return_det;
    logic               ld_en;
    logic [CNT_W-1:0]   ld_len;
    logic [2:0]         ld_cause;

    function automatic logic src_hit(input logic [REG_W-1:0] a, input logic rd,
                                     input logic wen, input logic [REG_W-1:0] dst);
        return rd && wen && (a == dst) && !((ZERO_HARDWIRED != 0) && (a == '0));
    endfunction

    // A loaded EX value cannot be forwarded, so WB may still supply that source.
    always_comb begin
        fwd_sel  = '0;
        load_use = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (src_hit(src_addr[i*REG_W +: REG_W], src_read[i], ex_wen, ex_addr) && !ex_is_load)
                fwd_sel[2*i +: 2] = 2'b01;
            else if (src_hit(src_addr[i*REG_W +: REG_W], src_read[i], wb_wen, wb_addr))
                fwd_sel[2*i +: 2] = 2'b10;
            if (src_hit(src_addr[i*REG_W +: REG_W], src_read[i], ex_wen, ex_addr) && ex_is_load)
                load_use = 1'b1;
        end
        if (reset)
            fwd_sel = '0;
    end

    assign call_det   = (instr_type == 4'h6);
    assign return_det = (instr_type inside {4'h7, 4'h8, 4'h9});

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= (FLUSH_RST == 0) ? CHECK : FLUSH;
            cnt         <= CNT_W'(FLUSH_RST);
            flush_cause <= (FLUSH_RST == 0) ? 3'd0 : 3'd1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            flush_cause <= cause_nxt;
        end
    end

    // Interrupt reloads the counter in either state; other events only start a flush from CHECK.
    always_comb begin
        ld_en    = 1'b1;
        ld_len   = '0;
        ld_cause = 3'd0;
        if (interrupt) begin
            ld_len   = CNT_W'(FLUSH_INT);
            ld_cause = 3'd2;
        end else if (state == FLUSH || load_use) begin
            ld_en = 1'b0;
        end else if (call_det) begin
            ld_len   = CNT_W'(FLUSH_CALL);
            ld_cause = 3'd4;
        end else if (branch_taken) begin
            ld_len   = CNT_W'(FLUSH_BR);
            ld_cause = 3'd3;
        end else if (return_det) begin
            ld_len   = CNT_W'(FLUSH_RET);
            ld_cause = 3'd5;
        end else begin
            ld_en = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cause_nxt = flush_cause;
        if (ld_en) begin
            if (ld_len == '0) begin
                state_nxt = CHECK;
                cnt_nxt   = '0;
                cause_nxt = 3'd0;
            end else begin
                state_nxt = FLUSH;
                cnt_nxt   = ld_len;
                cause_nxt = ld_cause;
            end
        end else if (state == FLUSH) begin
            if (cnt <= CNT_W'(1)) begin
                state_nxt = CHECK;
                cnt_nxt   = '0;
                cause_nxt = 3'd0;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        pc_reset    = reset;
        dec_nop     = 1'b0;
        fetch_stall = 1'b0;
        pc_load     = 1'b0;
        if (reset) begin
            dec_nop = 1'b1;
        end else if (interrupt) begin
            pc_load = 1'b1;
            dec_nop = 1'b1;
        end else if (state == FLUSH) begin
            dec_nop = 1'b1;
        end else if (load_use) begin
            fetch_stall = 1'b1;
            dec_nop     = 1'b1;
        end else if (call_det) begin
            dec_nop = 1'b1;
        end else if (branch_taken) begin
            pc_load = 1'b1;
            dec_nop = 1'b1;
        end else if (return_det) begin
            pc_load     = 1'b1;
            fetch_stall = 1'b1;
            dec_nop     = 1'b1;
        end
        pc_inc       = !reset && !pc_load && !fetch_stall;
        flush_active = (state == FLUSH);
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard/flush controller for the pipelined RAT core. It sits between decode, execute and writeback, and generates the PC control, fetch-stall and decode-squash signals. Unlike the fixed-enum predecessor, it resolves RAW hazards by per-source forwarding selects and stalls only on load-use. Flush lengths are programmable per event through a single down-counting flush FSM, and the cause of the active flush is reported.

Parameters:
REG_W, 5, register address width
NSRC, 2, number of decode source operands
ZERO_HARDWIRED, 0, if 1 then address 0 never matches (hazard/forward)
FLUSH_RST, 2, squash cycles after reset deasserts
FLUSH_INT, 2, squash cycles after interrupt cycle
FLUSH_BR, 2, squash cycles after taken branch
FLUSH_CALL, 2, squash cycles after call (instr_type 4'h6)
FLUSH_RET, 3, squash cycles after return (instr_type 4'h7/8/9)
CNT_W, 4, flush counter width; every FLUSH_* must be < 2**CNT_W

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
src_addr  in  NSRC*REG_W  decode source addresses; source i = bits [i*REG_W +: REG_W]
src_read  in  NSRC  source i actually read
ex_addr  in  REG_W  EX destination
ex_wen  in  1  EX writes register
ex_is_load  in  1  EX result comes from memory (not forwardable)
wb_addr  in  REG_W  WB destination
wb_wen  in  1  WB writes register
instr_type  in  4  decode instruction class
branch_taken  in  1  EX branch resolved taken
interrupt  in  1  interrupt accepted this cycle
fwd_sel  out  2*NSRC  per-source select: 00 regfile, 01 EX, 10 WB
fetch_stall  out  1  hold fetch latch and imem address
dec_nop  out  1  squash decode output into bubble
pc_inc  out  1  PC increment
pc_load  out  1  PC load
pc_reset  out  1  PC reset (= reset)
flush_active  out  1  FSM in FLUSH
flush_cause  out  3  0 none, 1 reset, 2 int, 3 branch, 4 call, 5 return (registered)

Behaviour:
- match(i,X): src_read[i], X_wen, src address == X_addr, and not (ZERO_HARDWIRED and address == 0).
- fwd_sel[i]:
  - 01 if match(i,EX) and !ex_is_load;
  - else 10 if match(i,WB);
  - else 00.
  - EX has priority over WB. Combinational; valid in every state; 00 while reset.
- load_use = any match(i,EX) with ex_is_load.
- return_det = instr_type in {7,8,9}. call_det = instr_type == 6.
- Two states: CHECK, FLUSH. Registers: state, cnt[CNT_W], flush_cause.
- Event priority: reset > interrupt > load_use > call > branch_taken > return.
- In CHECK, event cycle:
  - load_use: fetch_stall=1, dec_nop=1, pc_inc=0. No state change. The stall persists while the condition holds; the inserted bubble clears it the next cycle.
  - call: dec_nop=1; goto FLUSH, cnt<=FLUSH_CALL, cause<=4.
  - branch_taken: pc_load=1, dec_nop=1; goto FLUSH, cnt<=FLUSH_BR, cause<=3.
  - return: pc_load=1, fetch_stall=1, dec_nop=1; goto FLUSH, cnt<=FLUSH_RET, cause<=5.
  - Branch and return in the same cycle are treated as branch.
- Interrupt, in any state: pc_load=1, dec_nop=1, fetch_stall=0; goto FLUSH, cnt<=FLUSH_INT, cause<=2. Reloading the counter mid-flush is required.
- Reset:
  - While high: pc_reset=1, dec_nop=1, pc_inc=0, pc_load=0, fetch_stall=0, fwd_sel=0.
  - Next state FLUSH with cnt<=FLUSH_RST, cause<=1. Reset overrides all events and any flush in progress.
- FLUSH:
  - dec_nop=1, flush_active=1, fetch_stall=0, pc_inc=1 unless interrupt/reset.
  - instr_type, branch_taken and load_use are ignored.
  - cnt decrements each cycle; when cnt==1, next state is CHECK and cause<=0.
- A FLUSH_*=0 event squashes only its own cycle and stays in CHECK, with cause unchanged at 0.
- pc_inc = !reset & !pc_load & !fetch_stall.
- Out of reset, the block is in CHECK with cause 0 only after FLUSH_RST cycles.

Test Plan:
- Reset high 3 cycles then low -> pc_reset=1 and dec_nop=1 during reset; flush_active=1, cause=1 for exactly 2 cycles; then CHECK, pc_inc=1.
- src0=r3 read, ex_addr=r3 ex_wen, not load; wb_addr=r3 wb_wen -> fwd_sel[1:0]=01, no stall. Same case with ex_wen=0 -> fwd_sel[1:0]=10.
- src1=r7, ex_addr=r7, ex_is_load=1 for one cycle, r7 in WB next cycle -> cycle0: fetch_stall=1, dec_nop=1, pc_inc=0; cycle1: fwd_sel[3:2]=10, no stall.
- instr_type=7 in CHECK -> pc_load=1, fetch_stall=1 that cycle; then dec_nop=1 for 3 cycles, cause=5; branch_taken pulsed during the flush has no effect.
- Branch flush in progress (cnt=1), interrupt asserted -> pc_load=1, cnt reloads to 2, cause=2, dec_nop held for 2 more cycles.
- ZERO_HARDWIRED=1, src0=r0, ex_addr=r0, ex_is_load=1 -> no stall, fwd_sel=00.
